muldiv_unit: RTL

Iterative multiply/divide unit for the EX stage, alongside the ALU. It consumes the two register-file read operands and produces the 64-bit HI/LO result pair for MULT, MULTU, DIV and DIVU. It also owns the architectural HI and LO registers, including direct MTHI/MTLO writes. A `busy` output lets the pipeline stall any instruction that depends on HI/LO.

---
 rtl/muldiv_unit_pkg.sv | 26 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the EX-stage multiply/divide unit: op codes, FSM
// state encoding and small op-decoding helpers.
package muldiv_unit_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unit: a shift-add multiply step or a restoring
// divide step on the shared 2N-bit accumulator.
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [1:0]     op,
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   opnd,
    output logic [2*N-1:0] acc_next
);

    logic [N:0] sum_s;
    logic [N:0] rem_sh_s;
    logic [N:0] diff_s;

    // Multiply: {hi,lo} with the multiplier consumed from lo[0].
    // Divide: {remainder, dividend/quotient}; diff_s[N] is the borrow.
    always_comb begin
        sum_s    = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : {(N+1){1'b0}});
        rem_sh_s = {acc[2*N-1:N], acc[N-1]};
        diff_s   = rem_sh_s - {1'b0, opnd};
        if (is_div_op(op)) begin
            if (!diff_s[N]) begin
                acc_next = {diff_s[N-1:0], acc[N-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh_s[N-1:0], acc[N-2:0], 1'b0};
            end
        end else begin
            acc_next = {sum_s, acc[N-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO
// registers; N iterations plus one commit cycle per operation.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] inA,
    input  logic [N-1:0] inB,
    input  logic         hi_wen,
    input  logic         lo_wen,
    input  logic [N-1:0] wd,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]  CNT_N  = CW'(N);
    localparam logic [CW-1:0]  CNT_1  = CW'(1);
    localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};

    md_state_e      state_r, state_s;
    logic [CW-1:0]  cnt_r, cnt_s;
    logic [2*N-1:0] acc_r, acc_s, step_acc_s;
    logic [N-1:0]   opnd_r, opnd_s;
    logic [1:0]     op_r, op_s;
    logic           sign_a_r, sign_a_s, sign_b_r, sign_b_s;
    logic [N-1:0]   hi_r, hi_s, lo_r, lo_s;
    logic           busy_r, busy_s, done_r, done_s, dbz_r, dbz_s;
    logic [N-1:0]   mag_a_s, mag_b_s;

    muldiv_step #(.N(N)) u_step (
        .op       (op_r),
        .acc      (acc_r),
        .opnd     (opnd_r),
        .acc_next (step_acc_s)
    );

    // Next-state, datapath and output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        acc_s    = acc_r;
        opnd_s   = opnd_r;
        op_s     = op_r;
        sign_a_s = sign_a_r;
        sign_b_s = sign_b_r;
        hi_s     = hi_r;
        lo_s     = lo_r;
        busy_s   = busy_r;
        done_s   = 1'b0;
        dbz_s    = 1'b0;
        mag_a_s  = (is_signed_op(op) && inA[N-1]) ? (~inA + ONE_N) : inA;
        mag_b_s  = (is_signed_op(op) && inB[N-1]) ? (~inB + ONE_N) : inB;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (hi_wen) begin
                    hi_s = wd;
                end else begin
                    hi_s = hi_r;
                end
                if (lo_wen) begin
                    lo_s = wd;
                end else begin
                    lo_s = lo_r;
                end
                if (start) begin
                    state_s  = ST_RUN;
                    cnt_s    = {CW{1'b0}};
                    // Multiplier or dividend enters the low half.
                    acc_s    = {{N{1'b0}}, (is_div_op(op) ? mag_a_s : mag_b_s)};
                    opnd_s   = is_div_op(op) ? mag_b_s : mag_a_s;
                    op_s     = op;
                    sign_a_s = inA[N-1];
                    sign_b_s = inB[N-1];
                    busy_s   = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                    busy_s   = 1'b0;
                end
            end
            ST_RUN: begin
                if (cnt_r != CNT_N) begin
                    acc_s  = step_acc_s;
                    cnt_s  = cnt_r + CNT_1;
                    busy_s = 1'b1;
                end else begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    if (is_div_op(op_r)) begin
                        if (opnd_r == {N{1'b0}}) begin
                            dbz_s = 1'b1;
                        end else begin
                            lo_s = (is_signed_op(op_r) && (sign_a_r ^ sign_b_r))
                                   ? (~acc_r[N-1:0] + ONE_N) : acc_r[N-1:0];
                            hi_s = (is_signed_op(op_r) && sign_a_r)
                                   ? (~acc_r[2*N-1:N] + ONE_N) : acc_r[2*N-1:N];
                        end
                    end else begin
                        {hi_s, lo_s} = (is_signed_op(op_r) && (sign_a_r ^ sign_b_r))
                                       ? (~acc_r + ONE_2N) : acc_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset discards any in-flight result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*N){1'b0}};
            opnd_r   <= {N{1'b0}};
            op_r     <= 2'd0;
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            hi_r     <= {N{1'b0}};
            lo_r     <= {N{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            acc_r    <= acc_s;
            opnd_r   <= opnd_s;
            op_r     <= op_s;
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
            hi_r     <= hi_s;
            lo_r     <= lo_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            dbz_r    <= dbz_s;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign div_by_zero = dbz_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule
